data_memory_pipelined: RTL and testbench
========================================

DATA_MEMORY_PIPELINED -- requirements
Module: data_memory_pipelined

Interface
REQ-001 SHALL have parameter DATA_W, default 64, access width in bits (32 or 64).
REQ-002 SHALL have parameter DEPTH_BYTES, default 1024, memory size in bytes (power of two, multiple of DATA_W/8).
REQ-003 SHALL have parameter RD_LAT, default 1, response latency in cycles (1..3).
REQ-004 SHALL have localparam ADDR_W = log2(DEPTH_BYTES).
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request may be accepted this cycle.
REQ-009 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double (3 legal only when DATA_W = 64).
REQ-011 SHALL have port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-012 SHALL have port req_addr  input  DATA_W  byte address.
REQ-013 SHALL have port req_wdata  input  DATA_W  store data; low bytes used.
REQ-014 SHALL have port rsp_valid  output  1  response present, one-cycle pulse per accepted request.
REQ-015 SHALL have port rsp_rdata  output  DATA_W  load result after extension; 0 for stores and errors.
REQ-016 SHALL have port rsp_err  output  1  access was illegal; the memory is left unmodified.

Function
REQ-017 SHALL accept a request in a cycle where req_valid and req_ready are both 1.
REQ-018 SHALL store bytes little-endian: byte k of the data maps to address addr+k, for k < 2^req_size.
REQ-019 SHALL commit a legal store at the acceptance edge.
REQ-020 SHALL give a load accepted in the cycle after a store the stored data.
REQ-021 SHALL assert rsp_valid exactly RD_LAT cycles after acceptance for loads and stores alike; responses stay in request order and form a fully pipelined path with throughput of 1 per cycle.
REQ-022 SHALL give a legal load the read bytes extended to DATA_W per req_unsigned.
REQ-023 SHALL flag an error when any req_addr bit at or above ADDR_W is set.
REQ-024 SHALL flag an error when addr + 2^req_size exceeds DEPTH_BYTES; there is no wrap-around.
REQ-025 SHALL flag an error when req_size = 3 and DATA_W = 32.
REQ-026 SHALL, for an error, assert rsp_err with rsp_valid, drive rsp_rdata to 0, and leave the memory unmodified.
REQ-027 SHALL implement a state machine with states CLEAR and RUN.
REQ-028 SHALL, in CLEAR, zero one DATA_W-wide row per cycle using a row counter from 0 to DEPTH_BYTES*8/DATA_W - 1, hold req_ready at 0, then go to RUN.
REQ-029 SHALL, in RUN, hold req_ready at 1.
REQ-030 SHALL drive rsp_valid, rsp_err and rsp_rdata to 0 in every cycle without a response.

Reset
REQ-031 SHALL, while rst is 0 at a clock edge, enter CLEAR with the row counter at 0.
REQ-032 SHALL, while rst is 0 at a clock edge, set all pipeline valid bits, rsp_valid, rsp_err and rsp_rdata to 0.
REQ-033 SHALL, on reset mid-operation, discard in-flight responses; a store accepted in that cycle is not committed.
REQ-034 SHALL be cleared by CLEAR after every reset.
REQ-035 SHALL, outside simulation, guarantee no contents other than zero.

Configuration
REQ-036 SHALL, with macro DM_MISALIGN_EN defined, allow accesses that are not aligned to their size, including accesses that cross a DATA_W row, subject only to REQ-023..REQ-025.
REQ-037 SHALL, without DM_MISALIGN_EN, treat an access whose addr mod 2^req_size is not 0 as an error under REQ-026.

Verification (DATA_W=64, DEPTH_BYTES=256, RD_LAT=2)
REQ-038 SHALL test reset release: req_ready = 0 for exactly 32 cycles, then 1, and a load of double at 0x00 returns 0.
REQ-039 SHALL test store double 0x8877665544332211 at 0x10, then load byte signed at 0x17 -> rsp_rdata 0xFFFFFFFFFFFFFF88; load half unsigned at 0x16 -> 0x0000000000008877; each rsp_valid 2 cycles after acceptance.
REQ-040 SHALL test back-to-back store word 0xDEADBEEF at 0x20 followed next cycle by load word unsigned at 0x20 -> 0x00000000DEADBEEF; 4 consecutive requests yield 4 consecutive rsp_valid pulses.
REQ-041 SHALL test store double at 0xFC -> rsp_err 1 and bytes 0xFC..0xFF unchanged; a load at 0x100 -> rsp_err 1 and rsp_rdata 0.
REQ-042 SHALL test load word at 0x0E: with DM_MISALIGN_EN it returns bytes 0x0E..0x11 with rsp_err 0; without it, rsp_err 1.
REQ-043 SHALL test rst driven 0 for one cycle with 2 loads in flight: no rsp_valid follows, and CLEAR re-runs for 32 cycles.

Source files
------------

// File: rtl/data_memory_pipelined.sv
// Byte-addressed data memory with fixed-latency pipelined responses and a post-reset CLEAR sweep.
// Define DM_MISALIGN_EN to allow unaligned (including row-crossing) accesses.
module data_memory_pipelined #(
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int ADDR_W = $clog2(DEPTH_BYTES);
  localparam int BPR    = DATA_W / 8;
  localparam int BPR_W  = $clog2(BPR);
  localparam int ROWS   = DEPTH_BYTES / BPR;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              clear_en;

  logic [7:0]        mem_q [DEPTH_BYTES];

  logic              pipe_v_q [RD_LAT];
  logic              pipe_e_q [RD_LAT];
  logic [DATA_W-1:0] pipe_d_q [RD_LAT];

  logic [3:0]        nbytes;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   end_addr;
  logic              err, accept, store_en;
  logic [DATA_W-1:0] raw, mask, ext;
  logic              sign;

  // NOTE: always_comb assigns every output a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    req_ready = 1'b0;
    clear_en  = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_en = 1'b1;
        row_d    = row_q + 1'b1;
        if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = RUN;
          row_d   = '0;
        end
      end
      RUN:     req_ready = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign nbytes   = 4'd1 << req_size;
  assign base     = req_addr[ADDR_W-1:0];
  assign end_addr = {1'b0, base} + (ADDR_W+1)'(nbytes);

`ifdef DM_MISALIGN_EN
  assign err = (|req_addr[DATA_W-1:ADDR_W])
             || (end_addr > (ADDR_W+1)'(DEPTH_BYTES))
             || ((req_size == 2'd3) && (DATA_W == 32));
`else
  logic [2:0] align_mask;
  assign align_mask = 3'(nbytes - 4'd1);
  assign err = (|req_addr[DATA_W-1:ADDR_W])
             || (end_addr > (ADDR_W+1)'(DEPTH_BYTES))
             || ((req_size == 2'd3) && (DATA_W == 32))
             || ((req_addr[2:0] & align_mask) != 3'd0);
`endif

  assign accept   = req_valid && req_ready;
  assign store_en = accept && req_we && !err;

  // Gather bytes starting at base, then zero- or sign-extend from the access size.
  always_comb begin
    raw  = '0;
    mask = '0;
    sign = 1'b0;
    for (int k = 0; k < BPR; k++) begin
      raw[8*k +: 8] = mem_q[base + ADDR_W'(k)];
      if (k < int'(nbytes))      mask[8*k +: 8] = 8'hFF;
      if (k == int'(nbytes) - 1) sign = raw[8*k + 7];
    end
    ext = raw & mask;
    if (!req_unsigned && sign) ext = ext | ~mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= CLEAR;
      row_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_e_q[i] <= 1'b0;
        pipe_d_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      pipe_v_q[0] <= accept;
      pipe_e_q[0] <= accept && err;
      pipe_d_q[0] <= (accept && !err && !req_we) ? ext : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_e_q[i] <= pipe_e_q[i-1];
        pipe_d_q[i] <= pipe_d_q[i-1];
      end
    end
  end

  // NOTE: the array has no reset port; the CLEAR sweep after every reset zeroes it row by row instead.
  always_ff @(posedge clock) begin
    if (rst) begin
      if (clear_en) begin
        for (int k = 0; k < BPR; k++)
          mem_q[(ADDR_W'(row_q) << BPR_W) + ADDR_W'(k)] <= 8'h00;
      end else if (store_en) begin
        for (int k = 0; k < BPR; k++)
          if (k < int'(nbytes)) mem_q[base + ADDR_W'(k)] <= req_wdata[8*k +: 8];
      end
    end
  end

  assign rsp_valid = pipe_v_q[RD_LAT-1];
  assign rsp_err   = pipe_e_q[RD_LAT-1];
  assign rsp_rdata = pipe_d_q[RD_LAT-1];

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Directed bench for data_memory_pipelined (DATA_W=64, DEPTH_BYTES=256, RD_LAT=2).
module tb_data_memory_pipelined;

  logic        clock = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  data_memory_pipelined #(.DATA_W(64), .DEPTH_BYTES(256), .RD_LAT(2)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] size,
                       input logic uns, input logic [63:0] addr, input logic [63:0] wdata);
    req_valid = v; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
  endtask

  task automatic transact(input vec_t v);
    check({v.name, "_ready"}, 64'(req_ready), 64'd1);
    drive(1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
    tick();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    check({v.name, "_early"}, 64'(rsp_valid), 64'd0);
    tick();
    check({v.name, "_valid"}, 64'(rsp_valid), 64'd1);
    check({v.name, "_data"}, rsp_rdata, v.exp_data);
    check({v.name, "_err"}, 64'(rsp_err), 64'(v.exp_err));
    tick();
  endtask

  // Counts cycles with req_ready low; also tracks any stray response in that window.
  task automatic count_clear(input string name);
    int cnt = 0;
    logic stray = 1'b0;
    while (!req_ready && cnt < 100) begin
      stray |= rsp_valid;
      cnt++;
      tick();
    end
    check({name, "_clear_cycles"}, 64'(cnt), 64'd32);
    check({name, "_no_rsp"}, 64'(stray), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{"ld_d_00",      1'b0, 2'd3, 1'b1, 64'h00, 64'h0, 64'h0, 1'b0};
    vecs[1]  = '{"st_d_10",      1'b1, 2'd3, 1'b0, 64'h10, 64'h8877665544332211, 64'h0, 1'b0};
    vecs[2]  = '{"ld_b_s_17",    1'b0, 2'd0, 1'b0, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0};
    vecs[3]  = '{"ld_h_u_16",    1'b0, 2'd1, 1'b1, 64'h16, 64'h0, 64'h0000000000008877, 1'b0};
    vecs[4]  = '{"ld_h_s_16",    1'b0, 2'd1, 1'b0, 64'h16, 64'h0, 64'hFFFFFFFFFFFF8877, 1'b0};
    vecs[5]  = '{"ld_w_s_14",    1'b0, 2'd2, 1'b0, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 1'b0};
    vecs[6]  = '{"ld_b_u_10",    1'b0, 2'd0, 1'b1, 64'h10, 64'h0, 64'h11, 1'b0};
    vecs[7]  = '{"st_d_fc",      1'b1, 2'd3, 1'b0, 64'hFC, 64'hCAFEF00DCAFEF00D, 64'h0, 1'b1};
    vecs[8]  = '{"ld_d_f8",      1'b0, 2'd3, 1'b1, 64'hF8, 64'h0, 64'h0, 1'b0};
    vecs[9]  = '{"ld_b_100",     1'b0, 2'd0, 1'b1, 64'h100, 64'h0, 64'h0, 1'b1};
    vecs[10] = '{"ld_b_ff",      1'b0, 2'd0, 1'b1, 64'hFF, 64'h0, 64'h0, 1'b0};
    vecs[11] = '{"ld_h_ff",      1'b0, 2'd1, 1'b1, 64'hFF, 64'h0, 64'h0, 1'b1};
`ifdef DM_MISALIGN_EN
    vecs[12] = '{"ld_w_0e",      1'b0, 2'd2, 1'b1, 64'h0E, 64'h0, 64'h0000000022110000, 1'b0};
`else
    vecs[12] = '{"ld_w_0e",      1'b0, 2'd2, 1'b1, 64'h0E, 64'h0, 64'h0, 1'b1};
`endif
    vecs[13] = '{"st_b_30",      1'b1, 2'd0, 1'b0, 64'h30, 64'hFFFFFFFFFFFFFFA5, 64'h0, 1'b0};
    vecs[14] = '{"ld_d_30",      1'b0, 2'd3, 1'b1, 64'h30, 64'h0, 64'hA5, 1'b0};
    vecs[15] = '{"ld_hi_addr",   1'b0, 2'd0, 1'b1, 64'h8000000000000010, 64'h0, 64'h0, 1'b1};

    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    repeat (3) tick();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_err",   64'(rsp_err), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    rst = 1'b1;
    count_clear("init");

    for (int i = 0; i < 16; i++) transact(vecs[i]);

    // Four back-to-back requests; responses must appear in cycles 2..5 in order.
    begin
      logic        exp_v [8];
      logic [63:0] exp_d [8];
      for (int i = 0; i < 8; i++) begin
        exp_v[i] = (i >= 2 && i < 6);
        exp_d[i] = 64'd0;
      end
      exp_d[3] = 64'h00000000DEADBEEF;
      exp_d[4] = 64'h00000000000000BE;
      exp_d[5] = 64'hFFFFFFFFFFFFDEAD;
      for (int i = 0; i < 8; i++) begin
        case (i)
          0:       drive(1'b1, 1'b1, 2'd2, 1'b0, 64'h20, 64'h12345678DEADBEEF);
          1:       drive(1'b1, 1'b0, 2'd2, 1'b1, 64'h20, 64'h0);
          2:       drive(1'b1, 1'b0, 2'd0, 1'b1, 64'h21, 64'h0);
          3:       drive(1'b1, 1'b0, 2'd1, 1'b0, 64'h22, 64'h0);
          default: drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
        endcase
        check($sformatf("b2b_valid_%0d", i), 64'(rsp_valid), 64'(exp_v[i]));
        check($sformatf("b2b_data_%0d", i), rsp_rdata, exp_d[i]);
        tick();
      end
    end

    // Reset with two loads in flight: no response may surface, and CLEAR runs again.
    drive(1'b1, 1'b0, 2'd3, 1'b1, 64'h10, 64'h0);
    tick();
    drive(1'b1, 1'b0, 2'd3, 1'b1, 64'h10, 64'h0);
    rst = 1'b0;
    tick();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
    rst = 1'b1;
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    count_clear("midrst");
    transact('{"ld_d_10_cleared", 1'b0, 2'd3, 1'b1, 64'h10, 64'h0, 64'h0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
